mem_read_gather: RTL and testbench
==================================

Name: mem_read_gather

Overview:
- Downstream consumer of a port-B read sequence on a dual-port memory (addressWidth 16, dataWidth 32).
- Samples the BEATS consecutive read words that follow a read-trigger pulse and packs them into one wide word. Beat 0 goes in the LSBs.
- Presents the packed word on a valid/ready output with backpressure.
- Flags triggers it cannot honour with a sticky overrun flag.

Parameters:
- DATA_WIDTH, 32, width of one memory read word.
- BEATS, 4, words gathered per trigger; legal range 2..16.
- READ_LATENCY, 2, cycles from the trigger pulse to the first valid word on rdData; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse aligned with the rising-edge read trigger that launches the read sequence.
- rdData  input  DATA_WIDTH  memory port-B read data.
- outData  output  DATA_WIDTH*BEATS  packed word; beat k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- outValid  output  1  packed word available.
- outReady  input  1  consumer accepts outData.
- busy  output  1  high in WAIT, GATHER and HOLD.
- overrun  output  1  sticky: a start pulse was dropped.
- clearOverrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; outData=0, outValid=0, busy=0, overrun=0; beat and latency counters 0.
- State IDLE:
  - start=1 loads the latency counter and goes to WAIT.
- State WAIT:
  - Counts so that beat 0 is sampled exactly READ_LATENCY cycles after the start cycle.
  - For start at cycle T, beat k is sampled from rdData at the clock edge ending cycle T+READ_LATENCY+k.
  - Beats are consecutive; there is no data-valid qualifier.
- State GATHER:
  - Each cycle writes rdData into lane beatCnt, then increments beatCnt.
  - After beat BEATS-1 goes to HOLD.
  - outValid=1 from cycle T+READ_LATENCY+BEATS.
- State HOLD:
  - outValid=1; outData stable until the handshake.
  - Handshake: outValid&&outReady at a rising edge.
  - Handshake with start=0: go to IDLE, outValid=0 next cycle.
  - Handshake with start=1 in the same cycle: start is accepted, go to WAIT. Back-to-back sequences lose no cycle.
- Dropped starts:
  - start=1 in WAIT or GATHER is ignored by the datapath and sets overrun.
  - start=1 in HOLD without a handshake is ignored by the datapath and sets overrun.
- overrun:
  - Cleared by clearOverrun=1.
  - If a set and a clear occur in the same cycle, set wins.
- outData lanes not yet rewritten keep their previous values. The consumer must use outData only while outValid=1.
- Counters sized with $clog2 of BEATS and of READ_LATENCY+1. No wrap within one sequence. beatCnt resets to 0 on every accepted start.
- Reset asserted mid-sequence aborts it immediately. The first start after deassertion begins a fresh sequence.

Optional Feature:
- Macro MEM_READ_GATHER_COUNT_EN.
- Defined:
  - Adds output port wordCount, 16 bits.
  - Increments by 1 on each output handshake and wraps 0xFFFF->0x0000.
  - Reset value 0; not affected by clearOverrun.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Basic gather (READ_LATENCY=2, BEATS=4, outReady=1):
  - Stimulus: start at cycle 10; rdData=0x11111111, 0x22222222, 0x33333333, 0x44444444 in cycles 12..15.
  - Required: outValid=1 in cycle 16 with outData=0x44444444_33333333_22222222_11111111; outValid=0 in cycle 17; busy=0 from cycle 17.
- Backpressure:
  - Stimulus: same gather, outReady=0 for cycles 16..25, then 1 in cycle 26.
  - Required: outValid=1 and outData constant through cycles 16..26; handshake in cycle 26; outValid=0 in cycle 27.
- Overrun:
  - Stimulus: start at 10 and again at 13.
  - Required: second pulse dropped; overrun=1 from cycle 14; first packed word still correct.
  - Stimulus: clearOverrun in cycle 20.
  - Required: overrun=0 from cycle 21.
- Back-to-back:
  - Stimulus: start coincides with the handshake in HOLD; second sequence data 0xA0..0xA3.
  - Required: second word valid exactly READ_LATENCY+BEATS cycles after that start cycle, =0x000000A3_000000A2_000000A1_000000A0; overrun stays 0.
- Reset mid-sequence:
  - Stimulus: reset low asynchronously in cycle 13 of a sequence started at 10, released at 15.
  - Required: outValid, busy, overrun all 0 immediately.
  - Stimulus: new start at 20 with data 0x5..0x8.
  - Required: outData=0x00000008_00000007_00000006_00000005.
- MEM_READ_GATHER_COUNT_EN defined:
  - Stimulus: three completed handshakes.
  - Required: wordCount=3.
  - Stimulus: preload by forcing to 0xFFFF, then one more handshake.
  - Required: wordCount=0x0000.

Source files
------------

// File: rtl/mem_read_gather.sv
// mem_read_gather
//
// Sits behind port B of a dual-port memory. A start pulse marks the read
// trigger. The block waits READ_LATENCY cycles, then captures BEATS
// consecutive rdData words into one wide word, with beat 0 in the LSBs.
// The packed word is offered on a valid/ready interface. A start pulse that
// cannot be honoured sets a sticky overrun flag.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   start         read-trigger pulse, one cycle wide
//   rdData        memory port-B read data
//   outData       packed word; beat k occupies [k*DATA_WIDTH +: DATA_WIDTH]
//   outValid      outData holds a complete word
//   outReady      the consumer accepts outData
//   busy          a sequence is in progress (WAIT, GATHER or HOLD)
//   overrun       sticky; a start pulse was dropped
//   clearOverrun  synchronous clear of overrun
//   wordCount     16-bit count of output handshakes; wraps at 0xFFFF.
//                 Present only when MEM_READ_GATHER_COUNT_EN is defined.
//
// Optional feature macro: MEM_READ_GATHER_COUNT_EN
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no sequence; waiting for start
// ST_WAIT   | counting out the memory read latency
// ST_GATHER | capturing one beat per cycle into lane beat_cnt
// ST_HOLD   | packed word valid; waiting for the handshake
module mem_read_gather #(
    parameter int DATA_WIDTH   = 32,
    parameter int BEATS        = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [DATA_WIDTH-1:0]       rdData,
    output logic [DATA_WIDTH*BEATS-1:0] outData,
    output logic                        outValid,
    input  logic                        outReady,
    output logic                        busy,
    output logic                        overrun,
`ifdef MEM_READ_GATHER_COUNT_EN
    output logic [15:0]                 wordCount,
`endif
    input  logic                        clearOverrun
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GATHER,
        ST_HOLD
    } state_t;

    // The start cycle itself counts as one latency cycle. With a latency of
    // 1 there is nothing left to wait for, so the first beat arrives in the
    // cycle right after start.
    localparam state_t LAUNCH = (READ_LATENCY == 1) ? ST_GATHER : ST_WAIT;

    state_t                      state_q, state_d;
    logic [BEAT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic [LAT_W-1:0]            lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH*BEATS-1:0] out_data_q, out_data_d;
    logic                        overrun_q, overrun_d;
    logic                        handshake;
    logic                        accept;
    logic                        drop;

    assign handshake = (state_q == ST_HOLD) && outReady;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        out_data_d = out_data_q;
        overrun_d  = overrun_q;
        accept     = 1'b0;
        drop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = start;
            end
            ST_WAIT: begin
                drop = start;
                if (lat_cnt_q <= LAT_W'(1)) begin
                    state_d = ST_GATHER;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_GATHER: begin
                drop = start;
                for (int k = 0; k < BEATS; k++) begin
                    if (beat_cnt_q == BEAT_W'(k)) begin
                        out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = rdData;
                    end
                end
                if (beat_cnt_q == LAST_BEAT) begin
                    state_d = ST_HOLD;
                end else begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    // A start that coincides with the handshake launches the
                    // next sequence directly, so back-to-back runs lose no cycle.
                    if (start) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    drop = start;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d    = LAUNCH;
            lat_cnt_d  = LAT_LOAD;
            beat_cnt_d = '0;
        end

        // When a clear and a set land in the same cycle, the set wins.
        if (clearOverrun) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            lat_cnt_q  <= '0;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            out_data_q <= out_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign outData  = out_data_q;
    assign outValid = (state_q == ST_HOLD);
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = overrun_q;

`ifdef MEM_READ_GATHER_COUNT_EN
    logic [15:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q + {15'd0, handshake};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign wordCount = word_count_q;
`endif

endmodule

// File: tb/tb_mem_read_gather.sv
module tb_mem_read_gather;

    localparam int DW = 32;
    localparam int NB = 4;
    localparam int RL = 2;
    localparam int OW = DW * NB;
    localparam logic [DW-1:0] JUNK = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] rdData;
    logic [OW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          busy;
    logic          overrun;
    logic          clearOverrun;
`ifdef MEM_READ_GATHER_COUNT_EN
    logic [15:0]   wordCount;
`endif

    always #5 clk = ~clk;

    mem_read_gather #(
        .DATA_WIDTH  (DW),
        .BEATS       (NB),
        .READ_LATENCY(RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rdData      (rdData),
        .outData     (outData),
        .outValid    (outValid),
        .outReady    (outReady),
        .busy        (busy),
        .overrun     (overrun),
`ifdef MEM_READ_GATHER_COUNT_EN
        .wordCount   (wordCount),
`endif
        .clearOverrun(clearOverrun)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a timeline view of the sequence. A sequence started
    // in cycle T owns rdData from cycles T+RL .. T+RL+NB-1, and its word is
    // valid from cycle T+RL+NB until it is accepted.
    bit            m_active;
    int            m_t;
    bit            m_ovr;
    logic [15:0]   m_cnt;
    logic [DW-1:0] rd_hist [int];

    typedef struct {
        logic          s;
        logic [DW-1:0] d;
        logic          clr;
        logic          ev;
        logic          eb;
        logic          eo;
        logic          cd;
        logic [OW-1:0] edata;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic s, input logic [DW-1:0] d, input logic clr,
                                input logic ev, input logic eb, input logic eo,
                                input logic cd, input logic [OW-1:0] edata);
        vec_t v;
        v.s = s; v.d = d; v.clr = clr; v.ev = ev; v.eb = eb; v.eo = eo;
        v.cd = cd; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_valid();
        return m_active && (cyc >= m_t + RL + NB);
    endfunction

    function automatic logic [OW-1:0] m_data();
        logic [OW-1:0] d;
        d = '0;
        for (int k = 0; k < NB; k++) d[k*DW +: DW] = rd_hist[m_t + RL + k];
        return d;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_ovr    = 1'b0;
        m_cnt    = 16'd0;
    endtask

    task automatic model_check();
        chk("mdl_valid", OW'(outValid), OW'(m_valid()));
        chk("mdl_busy", OW'(busy), OW'(m_active));
        chk("mdl_overrun", OW'(overrun), OW'(m_ovr));
        if (m_valid()) chk("mdl_data", outData, m_data());
`ifdef MEM_READ_GATHER_COUNT_EN
        chk("mdl_count", OW'(wordCount), OW'(m_cnt));
`endif
    endtask

    task automatic model_step(input logic s, input logic [DW-1:0] d, input logic r, input logic c);
        bit hs;
        bit dropped;
        rd_hist[cyc] = d;
        if (reset) begin
            hs      = m_valid() && r;
            dropped = 1'b0;
            if (!m_active) begin
                if (s) begin
                    m_active = 1'b1;
                    m_t      = cyc;
                end
            end else if (hs) begin
                if (s) m_t = cyc;
                else   m_active = 1'b0;
            end else if (s) begin
                dropped = 1'b1;
            end
            if (c) m_ovr = 1'b0;
            if (dropped) m_ovr = 1'b1;
            if (hs) m_cnt = m_cnt + 16'd1;
        end
        cyc++;
    endtask

    // One clock cycle: drive inputs, check against the model, advance.
    task automatic apply(input logic s, input logic [DW-1:0] d, input logic r, input logic c);
        start        = s;
        rdData       = d;
        outReady     = r;
        clearOverrun = c;
        model_check();
        model_step(s, d, r, c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, $urandom, 1'b1, 1'b0);
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) apply(1'b0, JUNK, 1'b1, 1'b0);
        reset = 1'b1;
    endtask

    task automatic gather_one();
        apply(1'b1, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < RL + NB; i++) apply(1'b0, $urandom, 1'b1, 1'b0);
        apply(1'b0, $urandom, 1'b1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [OW-1:0] w1;
        logic [OW-1:0] w2;
        logic [OW-1:0] w3;
        w1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        w2 = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
        w3 = {32'h00000008, 32'h00000007, 32'h00000006, 32'h00000005};

        reset = 1'b0; start = 1'b0; rdData = '0; outReady = 1'b1; clearOverrun = 1'b0;
        model_reset();
        #1;
        chk("rst_data", outData, '0);
        chk("rst_valid", OW'(outValid), '0);
        chk("rst_busy", OW'(busy), '0);
        chk("rst_overrun", OW'(overrun), '0);
        @(negedge clk);
        reset_dut();

        // Basic gather with a dropped second start and a later clear (cycles 10..21).
        tbl[0]  = mk(1'b1, JUNK,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tbl[1]  = mk(1'b0, JUNK,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tbl[2]  = mk(1'b0, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tbl[3]  = mk(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tbl[4]  = mk(1'b0, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        tbl[5]  = mk(1'b0, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        tbl[6]  = mk(1'b0, JUNK,         1'b0, 1'b1, 1'b1, 1'b1, 1'b1, w1);
        tbl[7]  = mk(1'b0, JUNK,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tbl[8]  = mk(1'b0, JUNK,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tbl[9]  = mk(1'b0, JUNK,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tbl[10] = mk(1'b0, JUNK,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tbl[11] = mk(1'b0, JUNK,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        idle(10);
        for (int i = 0; i < 12; i++) begin
            chk("tbl_valid", OW'(outValid), OW'(tbl[i].ev));
            chk("tbl_busy", OW'(busy), OW'(tbl[i].eb));
            chk("tbl_overrun", OW'(overrun), OW'(tbl[i].eo));
            if (tbl[i].cd) chk("tbl_data", outData, tbl[i].edata);
            apply(tbl[i].s, tbl[i].d, 1'b1, tbl[i].clr);
        end

        // Backpressure: hold from 16 to 25, accept in 26.
        idle(10);
        apply(1'b1, JUNK, 1'b1, 1'b0);
        apply(1'b0, JUNK, 1'b1, 1'b0);
        apply(1'b0, 32'h11111111, 1'b1, 1'b0);
        apply(1'b0, 32'h22222222, 1'b1, 1'b0);
        apply(1'b0, 32'h33333333, 1'b1, 1'b0);
        apply(1'b0, 32'h44444444, 1'b1, 1'b0);
        for (int c = 16; c <= 25; c++) begin
            chk("bp_valid", OW'(outValid), OW'(1'b1));
            chk("bp_data", outData, w1);
            apply(1'b0, $urandom, 1'b0, 1'b0);
        end
        chk("bp_valid26", OW'(outValid), OW'(1'b1));
        chk("bp_data26", outData, w1);
        apply(1'b0, JUNK, 1'b1, 1'b0);
        chk("bp_valid27", OW'(outValid), '0);
        chk("bp_busy27", OW'(busy), '0);

        // Back-to-back: the second start lands on the handshake in cycle 16.
        idle(10);
        apply(1'b1, JUNK, 1'b1, 1'b0);
        apply(1'b0, JUNK, 1'b1, 1'b0);
        apply(1'b0, 32'h11111111, 1'b1, 1'b0);
        apply(1'b0, 32'h22222222, 1'b1, 1'b0);
        apply(1'b0, 32'h33333333, 1'b1, 1'b0);
        apply(1'b0, 32'h44444444, 1'b1, 1'b0);
        chk("b2b_first", outData, w1);
        apply(1'b1, JUNK, 1'b1, 1'b0);
        chk("b2b_valid17", OW'(outValid), '0);
        chk("b2b_busy17", OW'(busy), OW'(1'b1));
        apply(1'b0, JUNK, 1'b1, 1'b0);
        apply(1'b0, 32'h000000A0, 1'b1, 1'b0);
        apply(1'b0, 32'h000000A1, 1'b1, 1'b0);
        apply(1'b0, 32'h000000A2, 1'b1, 1'b0);
        chk("b2b_valid21", OW'(outValid), '0);
        apply(1'b0, 32'h000000A3, 1'b1, 1'b0);
        chk("b2b_valid22", OW'(outValid), OW'(1'b1));
        chk("b2b_data", outData, w2);
        chk("b2b_overrun", OW'(overrun), '0);
        apply(1'b0, JUNK, 1'b1, 1'b0);

        // Reset in the middle of a sequence that has already set overrun.
        idle(10);
        apply(1'b1, JUNK, 1'b1, 1'b0);
        apply(1'b1, JUNK, 1'b1, 1'b0);
        apply(1'b0, 32'h11111111, 1'b1, 1'b0);
        chk("mid_overrun_pre", OW'(overrun), OW'(1'b1));
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_valid", OW'(outValid), '0);
        chk("mid_busy", OW'(busy), '0);
        chk("mid_overrun", OW'(overrun), '0);
        chk("mid_data", outData, '0);
        apply(1'b0, 32'h22222222, 1'b1, 1'b0);
        apply(1'b0, 32'h33333333, 1'b1, 1'b0);
        reset = 1'b1;
        idle(5);
        apply(1'b1, JUNK, 1'b1, 1'b0);
        apply(1'b0, JUNK, 1'b1, 1'b0);
        apply(1'b0, 32'h00000005, 1'b1, 1'b0);
        apply(1'b0, 32'h00000006, 1'b1, 1'b0);
        apply(1'b0, 32'h00000007, 1'b1, 1'b0);
        apply(1'b0, 32'h00000008, 1'b1, 1'b0);
        chk("mid_new_valid", OW'(outValid), OW'(1'b1));
        chk("mid_new_data", outData, w3);
        apply(1'b0, JUNK, 1'b1, 1'b0);

`ifdef MEM_READ_GATHER_COUNT_EN
        reset_dut();
        for (int i = 0; i < 3; i++) gather_one();
        chk("count_three", OW'(wordCount), OW'(16'd3));
        force dut.word_count_q = 16'hFFFF;
        #1;
        release dut.word_count_q;
        m_cnt = 16'hFFFF;
        gather_one();
        chk("count_wrap", OW'(wordCount), '0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 3) == 0), $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
